// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_if
//  Purpose  : Data-memory port between the core's M stage and the responder.
//             Carries the load/store request fields plus the read data, the
//             stall back to the pipeline and the busy debug flag.
//  Signals  : mem_en     request valid
//             mem_wen    byte write enables (0000 = load)
//             mem_addr   byte address
//             mem_wdata  lane-aligned store data
//             mem_rdata  load data, valid in the DONE cycle
//             mem_stall  stall request to the pipeline
//             mem_busy   registered, high while waiting on the RAM
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_if;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_busy;

  modport master (
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_stall, mem_busy
  );

  modport slave (
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_stall, mem_busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder for the M-stage data port. Latches one
//             word-addressed load/store, waits LATENCY cycles, then performs
//             the access on an internal RAM. The core is stalled from the
//             request cycle until the access has completed.
//  Ports    : clk  system clock (rising edge)
//             rst  asynchronous active-high reset
//             bus  dmem_if.slave: request fields in, rdata/stall/busy out
//  Params   : ADDR_W   log2 of RAM depth in 32-bit words
//             LATENCY  wait-state count, 1..15
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int         c_DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] c_LAT    = 4'(LATENCY);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_WAIT = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_count;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_wen;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_busy;
  logic [31:0]       r_ram [c_DEPTH];

  logic w_fire;
  logic w_unused_addr;

  // Byte offset and bits above the RAM range play no part in indexing,
  // which is what makes addresses alias modulo the RAM size.
  assign w_unused_addr = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  // Access happens on the edge that leaves WAIT.
  assign w_fire = (r_state == c_S_WAIT) && (r_count == 4'd1);

  // Stall is raised combinationally in the request cycle so the core never
  // advances past an unserviced access; forced low while reset is held.
  assign bus.mem_stall = !rst &&
                         (((r_state == c_S_IDLE) && bus.mem_en) ||
                          (r_state == c_S_WAIT));
  assign bus.mem_rdata = r_rdata;
  assign bus.mem_busy  = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_IDLE;
      r_count <= 4'd0;
      r_idx   <= '0;
      r_wen   <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.mem_en) begin
            r_idx   <= bus.mem_addr[ADDR_W+1:2];
            r_wen   <= bus.mem_wen;
            r_wdata <= bus.mem_wdata;
            r_count <= c_LAT;
            r_busy  <= 1'b1;
            r_state <= c_S_WAIT;
          end
        end
        c_S_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            // Loads update rdata; stores leave the last load value in place.
            if (r_wen == 4'd0) begin
              r_rdata <= r_ram[r_idx];
            end
            r_busy  <= 1'b0;
            r_state <= c_S_DONE;
          end
        end
        c_S_DONE: begin
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM is deliberately outside the reset domain; contents survive reset.
  // The rst gate drops a write whose completing edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && w_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wen[i]) begin
          r_ram[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's M-stage data port.
- Accepts a word-addressed load/store request from the core and services it from an internal RAM after a fixed number of wait states.
- Holds the core in M with a stall output until the read data is valid or the write has been committed.
- Sits between the core's data-memory outputs (address, write data, byte write enables) and the stall input of the hazard/stall logic.

Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words; word index = mem_addr[ADDR_W+1:2].
- LATENCY, 2, wait-state count before access completes; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_en  in  1  request valid; core holds it and all request fields stable while mem_stall=1.
- mem_wen  in  4  byte write enables, bit i -> byte lane i (bits 8i+7:8i); 0000 = load.
- mem_addr  in  32  byte address; bits [1:0] and bits above ADDR_W+1 ignored for indexing.
- mem_wdata  in  32  store data, lane-aligned.
- mem_rdata  out  32  load data; valid in DONE cycle only.
- mem_stall  out  1  stall request to the pipeline.
- mem_busy  out  1  registered; high in WAIT state (debug/perf counter).

Behaviour:
- Reset:
  - state=IDLE, counter=0, mem_rdata=0, mem_busy=0, mem_stall=0.
  - Latched request registers cleared.
  - RAM contents are not cleared by reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - mem_en=0: mem_stall=0, stay IDLE.
  - mem_en=1: mem_stall=1 combinationally in the same cycle.
  - On the edge: latch addr/wen/wdata, counter<=LATENCY, go WAIT.
- WAIT:
  - mem_stall=1, mem_busy=1, counter decrements each cycle.
  - When counter==1, perform the access on the edge leaving WAIT:
    - write: update only the lanes with wen bit set, from the latched wdata;
    - read: mem_rdata <= RAM[latched index].
  - Go DONE.
- DONE:
  - mem_stall=0, so the core captures mem_rdata and advances on this edge; always return to IDLE.
  - mem_rdata holds its value until the next read completes; writes do not change it.
- Latency:
  - Request first seen in cycle 0 -> DONE in cycle LATENCY+1 -> stall asserted for LATENCY+1 cycles.
- Back-to-back:
  - The next request is only sampled in IDLE, the cycle after DONE.
  - The DONE-cycle request fields are already serviced and are ignored.
- Changes of mem_en, mem_wen, mem_addr or mem_wdata during WAIT are ignored; only the latched copy is used.
- Partial writes:
  - wen=0001 writes only bits 7:0.
  - wen=1100 writes only bits 31:16.
  - No implicit lane shifting; the core aligns the data.
- Address aliasing: addresses equal modulo 2^(ADDR_W+2) map to the same word.
- Reset mid-operation (rst in WAIT or DONE):
  - Return immediately to IDLE with mem_stall=0.
  - A pending write is dropped; the RAM is not modified.
- No read-modify-write hazard: one access at a time by construction.

Test Plan:
- Reset release, mem_en=0 for 5 cycles -> mem_stall=0, mem_busy=0, mem_rdata=0 throughout.
- Store wen=1111, addr=0x10, wdata=0xDEADBEEF, then load addr=0x10 (LATENCY=2) -> each access stalls exactly 3 cycles; load DONE cycle gives mem_rdata=0xDEADBEEF.
- Partial stores:
  - Setup: word 0x20 preloaded with 0x11223344, then store wen=0010 wdata=0x0000AA00, then load 0x20.
  - Required: mem_rdata=0x1122AA44.
  - Repeat with wen=1000 wdata=0xFF000000 -> mem_rdata=0xFF22AA44.
- Request fields changed mid-WAIT:
  - Setup: load addr=0x10 issued, addr switched to 0x20 during WAIT.
  - Required: mem_rdata=word 0x10.
  - Store whose wdata changes mid-WAIT -> original wdata is written.
- Aliasing, ADDR_W=10: store to 0x1004 then load 0x0004 -> same data returned; stall length unchanged.
- Reset during WAIT of a store (wen=1111, wdata=0x12345678, addr=0x30, word previously 0) -> mem_stall=0 in the reset cycle; a later load of 0x30 returns 0x00000000.
